// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer. Counts down from a preset once per prescaled
// tick while count_enable is high, pauses with the partial tick kept, and stops at 00.
module bcd_countdown_timer #(
  parameter int unsigned CLK_DIV   = 100000000,
  parameter int unsigned INIT_TENS = 3,
  parameter int unsigned INIT_ONES = 0,
  parameter int unsigned DIV_W     = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       count_enable,
  input  logic       reload,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       tick,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

  localparam logic [DIV_W-1:0] PrescMax = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       InitTens = 4'(INIT_TENS);
  localparam logic [3:0]       InitOnes = 4'(INIT_ONES);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    tick_d  = 1'b0;
    done_d  = done_q;

    if (reload) begin
      state_d = StHold;
      presc_d = '0;
      tens_d  = InitTens;
      ones_d  = InitOnes;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (count_enable) state_d = StRun;
        end
        StRun: begin
          // Dropping enable freezes the prescaler, even at its terminal value.
          if (!count_enable) begin
            state_d = StHold;
          end else if (presc_q == PrescMax) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end
            if (tens_q == 4'd0 && ones_q == 4'd1) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StHold;
        end
      endcase
    end
  end

  // Reset is active-high and asynchronous despite the rst_n name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StHold;
      presc_q <= '0;
      tens_q  <= InitTens;
      ones_q  <= InitOnes;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign digit_tens = tens_q;
  assign digit_ones = ones_q;
  assign tick       = tick_q;
  assign done       = done_q;
  assign running    = (state_q == StRun);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random enable/reload,
// checked each cycle against a value-level countdown model.
module tb_bcd_countdown_timer;

  localparam int Div = 4;
  localparam int MHold = 0;
  localparam int MRun  = 1;
  localparam int MDone = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cen = 1'b0;
  logic       reload = 1'b0;
  logic [3:0] t1, o1, t2, o2;
  logic       tick1, run1, done1, tick2, run2, done2;

  bcd_countdown_timer #(
    .CLK_DIV(Div), .INIT_TENS(3), .INIT_ONES(0), .DIV_W(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .count_enable(cen), .reload(reload),
    .digit_tens(t1), .digit_ones(o1), .tick(tick1), .running(run1), .done(done1)
  );

  bcd_countdown_timer #(
    .CLK_DIV(Div), .INIT_TENS(0), .INIT_ONES(2), .DIV_W(3)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .count_enable(cen), .reload(reload),
    .digit_tens(t2), .digit_ones(o2), .tick(tick2), .running(run2), .done(done2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int   value;
    int   phase;
    int   mode;
    logic tick;
    logic done;
  } model_t;

  int     n_checks = 0;
  int     n_errors = 0;
  model_t m1, m2;

  function automatic model_t model_reset(input int preset);
    model_t m;
    m.value = preset;
    m.phase = 0;
    m.mode  = MHold;
    m.tick  = 1'b0;
    m.done  = 1'b0;
    return m;
  endfunction

  // Remaining time as a plain integer; one tick every Div enabled run cycles.
  function automatic model_t model_step(input model_t m, input logic en, input logic rl,
                                        input int preset);
    model_t n = m;
    n.tick = 1'b0;
    if (rl) return model_reset(preset);
    if (m.mode == MHold) begin
      if (en) n.mode = MRun;
    end else if (m.mode == MRun) begin
      if (!en) begin
        n.mode = MHold;
      end else if (m.phase == Div - 1) begin
        n.phase = 0;
        n.tick  = 1'b1;
        n.value = m.value - 1;
        if (n.value == 0) begin
          n.mode = MDone;
          n.done = 1'b1;
        end
      end else begin
        n.phase = m.phase + 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    check("tens1", 32'(t1), m1.value / 10);
    check("ones1", 32'(o1), m1.value % 10);
    check("tick1", 32'(tick1), 32'(m1.tick));
    check("running1", 32'(run1), 32'(m1.mode == MRun));
    check("done1", 32'(done1), 32'(m1.done));
    check("tens2", 32'(t2), m2.value / 10);
    check("ones2", 32'(o2), m2.value % 10);
    check("tick2", 32'(tick2), 32'(m2.tick));
    check("running2", 32'(run2), 32'(m2.mode == MRun));
    check("done2", 32'(done2), 32'(m2.done));
    check("bcd_range", 32'((t1 <= 4'd9) && (o1 <= 4'd9)), 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      m1 = model_reset(30);
      m2 = model_reset(2);
    end else begin
      m1 = model_step(m1, cen, reload, 30);
      m2 = model_step(m2, cen, reload, 2);
    end
    @(negedge clk);
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    int guard;

    m1 = model_reset(30);
    m2 = model_reset(2);
    #12;
    compare();
    rst_n = 1'b0;

    // Free-running count from 30 with the 02 instance reaching its end.
    cen = 1'b1;
    cycle();
    check("running_after_enable", 32'(run1), 1);
    lat = 0;
    do begin cycle(); lat++; end while (!tick1 && lat < 20);
    check("first_tick_latency", lat, Div);
    check("first_tick_digits", 32'({t1, o1}), 32'h29);
    cycle();
    check("tick_single_cycle", 32'(tick1), 0);
    lat = 1;
    while (!tick1 && lat < 20) begin cycle(); lat++; end
    check("second_tick_interval", lat, Div);
    check("second_tick_digits", 32'({t1, o1}), 32'h28);
    check("term_digits", 32'({t2, o2}), 0);
    check("term_done", 32'(done2), 1);
    check("term_running", 32'(run2), 0);
    cnt = 0;
    repeat (20) begin cycle(); cnt += int'(tick2); end
    check("term_no_tick", cnt, 0);
    check("term_digits_hold", 32'({t2, o2}), 0);

    // Pause mid-second keeps the partial prescale.
    reload = 1'b1; cen = 1'b0;
    cycle();
    reload = 1'b0; cen = 1'b1;
    cycle();
    repeat (2) cycle();
    cen = 1'b0;
    cnt = 0;
    repeat (10) begin cycle(); cnt += int'(tick1); end
    check("pause_no_tick", cnt, 0);
    cen = 1'b1;
    cycle();
    lat = 0;
    do begin cycle(); lat++; end while (!tick1 && lat < 20);
    check("resume_tick_latency", lat, 2);
    check("resume_tick_digits", 32'({t1, o1}), 32'h29);

    // Enable drops exactly when a tick is due.
    guard = 0;
    while (!(m1.mode == MRun && m1.phase == Div - 1) && guard < 20) begin cycle(); guard++; end
    cen = 1'b0;
    cycle();
    check("drop_at_max_no_tick", 32'(tick1), 0);
    repeat (3) cycle();
    cen = 1'b1;
    cycle();
    cycle();
    check("resume_at_max_tick", 32'(tick1), 1);

    // Reload collides with a due tick at 15.
    guard = 0;
    while (!(m1.value == 15 && m1.phase == Div - 1 && m1.mode == MRun) && guard < 400) begin
      cycle();
      guard++;
    end
    check("reach_15_digits", 32'({t1, o1}), 32'h15);
    reload = 1'b1;
    cycle();
    reload = 1'b0;
    check("reload_digits", 32'({t1, o1}), 32'h30);
    check("reload_tick", 32'(tick1), 0);
    check("reload_done", 32'(done1), 0);
    check("reload_running", 32'(run1), 0);
    cycle();
    check("reload_rerun", 32'(run1), 1);

    // Asynchronous reset between edges at 17.
    guard = 0;
    while (!(m1.value == 17 && m1.phase == 2) && guard < 400) begin cycle(); guard++; end
    check("reach_17_digits", 32'({t1, o1}), 32'h17);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_digits", 32'({t1, o1}), 32'h30);
    check("async_done", 32'(done1), 0);
    check("async_running", 32'(run1), 0);
    m1 = model_reset(30);
    m2 = model_reset(2);
    compare();
    @(negedge clk);
    repeat (2) cycle();
    rst_n = 1'b0;
    cen = 1'b0;
    cycle();
    check("post_reset_hold", 32'(run1), 0);
    cen = 1'b1;
    cycle();
    lat = 0;
    do begin cycle(); lat++; end while (!tick1 && lat < 20);
    check("post_reset_latency", lat, Div);

    // Random enable and occasional reload.
    repeat (800) begin
      cen    = ($urandom_range(0, 9) != 0);
      reload = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reload = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
